// File: rtl/pc_seq_itr.sv
// Program sequencer: PC, subroutine return stack and prioritised vectored interrupts.
// Define ITR_NEST_EN to let a lower-index line preempt an active interrupt service.
module pc_seq_itr #(
  parameter int unsigned MINSTW  = 9,
  parameter int unsigned SDEPTH  = 8,
  parameter int unsigned NITR    = 4,
  parameter int unsigned ITRBASE = 1,
  parameter int unsigned ITRSTEP = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         jmp,
  input  logic                         jz,
  input  logic                         acc_zero,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         reti,
  input  logic [MINSTW-1:0]            target,
  input  logic [NITR-1:0]              itr,
  input  logic [NITR-1:0]              itr_mask,
  output logic [MINSTW-1:0]            instr_addr,
  output logic [NITR-1:0]              itr_ack,
  output logic                         in_isr,
  output logic [$clog2(SDEPTH+1)-1:0]  depth,
  output logic                         stk_full,
  output logic                         stk_empty,
  output logic                         stk_ovf,
  output logic                         stk_udf
);
  localparam int unsigned DW = $clog2(SDEPTH + 1);
  localparam int unsigned AW = $clog2(SDEPTH);
  localparam int unsigned IW = $clog2(NITR + 1);
`ifdef ITR_NEST_EN
  localparam int unsigned EW = MINSTW + IW;
`else
  localparam int unsigned EW = MINSTW;
`endif

  logic [EW-1:0]     stk [SDEPTH];
  logic [EW-1:0]     push_entry, top;
  logic [NITR-1:0]   itr_q, pending, avail, acc_vec;
  logic [MINSTW-1:0] pc_inc, nxt, push_addr, vec_addr, top_addr;
  logic [IW-1:0]     win_idx;
  logic              found, allow, accept, push, pop, set_ovf, set_udf, do_reti;
`ifdef ITR_NEST_EN
  logic [IW-1:0]     active, top_idx;
`endif

  assign stk_full  = (depth == DW'(SDEPTH));
  assign stk_empty = (depth == '0);
  assign top       = stk[AW'(depth - DW'(1))];
  assign top_addr  = top[MINSTW-1:0];
`ifdef ITR_NEST_EN
  assign top_idx    = top[EW-1:MINSTW];
  assign push_entry = {active, push_addr};
`else
  assign push_entry = push_addr;
`endif

  // Next address from the strobes, then interrupt arbitration on top of it
  always_comb begin
    pc_inc    = instr_addr + MINSTW'(1);
    nxt       = pc_inc;
    push      = 1'b0;
    pop       = 1'b0;
    push_addr = pc_inc;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    do_reti   = ~call & reti;
    if (call) begin
      nxt     = target;
      push    = ~stk_full;
      set_ovf = stk_full;
    end else if (ret | reti) begin
      pop     = ~stk_empty;
      set_udf = stk_empty;
      if (!stk_empty) nxt = top_addr;
    end else if (jmp | (jz & acc_zero)) begin
      nxt = target;
    end

    avail   = pending & ~itr_mask;
    found   = 1'b0;
    win_idx = IW'(NITR);
    for (int i = int'(NITR) - 1; i >= 0; i--) begin
      if (avail[i]) begin
        found   = 1'b1;
        win_idx = IW'(i);
      end
    end
`ifdef ITR_NEST_EN
    allow = (win_idx < active);
`else
    allow = ~in_isr;
`endif
    accept   = en & found & allow & ~call & ~ret & ~reti & ~stk_full;
    acc_vec  = accept ? (NITR'(1) << win_idx) : '0;
    vec_addr = MINSTW'(ITRBASE + ITRSTEP * 32'(win_idx));
    // Interrupt entry saves the address the program would have gone to next
    if (accept) begin
      push      = 1'b1;
      push_addr = nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_addr <= '0;
      depth      <= '0;
      itr_q      <= '0;
      pending    <= '0;
      itr_ack    <= '0;
      in_isr     <= 1'b0;
      stk_ovf    <= 1'b0;
      stk_udf    <= 1'b0;
`ifdef ITR_NEST_EN
      active     <= IW'(NITR);
`endif
    end else begin
      itr_q   <= itr;
      pending <= (pending & ~acc_vec) | (itr & ~itr_q);
      itr_ack <= acc_vec;
      if (en) begin
        instr_addr <= accept ? vec_addr : nxt;
        if (push)     depth <= depth + DW'(1);
        else if (pop) depth <= depth - DW'(1);
        if (set_ovf) stk_ovf <= 1'b1;
        if (set_udf) stk_udf <= 1'b1;
        if (accept) begin
          in_isr <= 1'b1;
`ifdef ITR_NEST_EN
          active <= win_idx;
`endif
        end else if (do_reti) begin
`ifdef ITR_NEST_EN
          if (pop) begin
            active <= top_idx;
            in_isr <= (top_idx != IW'(NITR));
          end else begin
            active <= IW'(NITR);
            in_isr <= 1'b0;
          end
`else
          in_isr <= 1'b0;
`endif
        end
      end
    end
  end

  // Stack storage needs no reset; only depth defines valid entries
  always_ff @(posedge clk) begin
    if (en && push) stk[AW'(depth)] <= push_entry;
  end

endmodule

// File: tb/tb_pc_seq_itr.sv
// Bench for pc_seq_itr: queue-based reference model compared every cycle, directed
// literal expectations from the test plan, then randomized strobes and interrupts.
module tb_pc_seq_itr;
  localparam int unsigned MINSTW  = 9;
  localparam int unsigned SDEPTH  = 8;
  localparam int unsigned NITR    = 4;
  localparam int unsigned ITRBASE = 1;
  localparam int unsigned ITRSTEP = 2;
  localparam int unsigned DW      = $clog2(SDEPTH + 1);

  logic clk = 1'b0;
  logic rst, en, jmp, jz, acc_zero, call, ret, reti;
  logic [MINSTW-1:0] target;
  logic [NITR-1:0]   itr, itr_mask;
  logic [MINSTW-1:0] instr_addr;
  logic [NITR-1:0]   itr_ack;
  logic              in_isr, stk_full, stk_empty, stk_ovf, stk_udf;
  logic [DW-1:0]     depth;

  pc_seq_itr #(.MINSTW(MINSTW), .SDEPTH(SDEPTH), .NITR(NITR),
               .ITRBASE(ITRBASE), .ITRSTEP(ITRSTEP)) dut (
    .clk(clk), .rst(rst), .en(en), .jmp(jmp), .jz(jz), .acc_zero(acc_zero),
    .call(call), .ret(ret), .reti(reti), .target(target), .itr(itr),
    .itr_mask(itr_mask), .instr_addr(instr_addr), .itr_ack(itr_ack),
    .in_isr(in_isr), .depth(depth), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_ovf(stk_ovf), .stk_udf(stk_udf));

  always #5 clk = ~clk;

  // Reference model: the stack is a queue of {return address, active line}
  typedef struct { logic [MINSTW-1:0] addr; int idx; } ent_t;
  ent_t              m_stk[$];
  logic [MINSTW-1:0] m_pc;
  logic [NITR-1:0]   m_pend, m_prev, m_ack;
  bit                m_isr, m_ovf, m_udf;
  int                m_act;

  function automatic void model_reset();
    m_stk.delete();
    m_pc = '0; m_pend = '0; m_prev = '0; m_ack = '0;
    m_isr = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_act = int'(NITR);
  endfunction

  function automatic void model_step();
    logic [NITR-1:0]   rise;
    logic [MINSTW-1:0] seq, nxt;
    int                win;
    bit                gate, take;
    ent_t              e;
    rise = itr & ~m_prev;
    seq  = m_pc + 1'b1;
    win  = -1;
    for (int k = int'(NITR) - 1; k >= 0; k--)
      if (m_pend[k] && !itr_mask[k]) win = k;
`ifdef ITR_NEST_EN
    gate = (win < m_act);
`else
    gate = !m_isr;
`endif
    take = en && win >= 0 && !(call || ret || reti) && m_stk.size() < int'(SDEPTH) && gate;
    m_ack = '0;
    if (en) begin
      nxt = seq;
      if (call) begin
        if (m_stk.size() == int'(SDEPTH)) m_ovf = 1'b1;
        else begin e.addr = seq; e.idx = m_act; m_stk.push_back(e); end
        nxt = target;
      end else if (ret || reti) begin
        if (m_stk.size() == 0) begin
          m_udf = 1'b1;
          if (reti) begin m_isr = 1'b0; m_act = int'(NITR); end
        end else begin
          e = m_stk.pop_back();
          nxt = e.addr;
          if (reti) begin
`ifdef ITR_NEST_EN
            m_act = e.idx;
            m_isr = (e.idx != int'(NITR));
`else
            m_isr = 1'b0;
`endif
          end
        end
      end else if (jmp || (jz && acc_zero)) begin
        nxt = target;
      end
      if (take) begin
        e.addr = nxt; e.idx = m_act; m_stk.push_back(e);
        m_pc = MINSTW'(ITRBASE + ITRSTEP * 32'(win));
        m_isr = 1'b1; m_act = win;
        m_ack[win] = 1'b1; m_pend[win] = 1'b0;
      end else begin
        m_pc = nxt;
      end
    end
    m_pend = m_pend | rise;
    m_prev = itr;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Compare process: model every cycle plus literal pins from the stimulus
  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0, lit_en = 1'b0;
  string lit_nm;
  logic [MINSTW-1:0] lit_pc;
  int lit_dep;
  logic [NITR-1:0] lit_ack;
  bit lit_isr, lit_ovf, lit_udf;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("instr_addr", 32'(instr_addr), 32'(m_pc));
      check("itr_ack", 32'(itr_ack), 32'(m_ack));
      check("in_isr", 32'(in_isr), 32'(m_isr));
      check("depth", 32'(depth), 32'(m_stk.size()));
      check("stk_full", 32'(stk_full), 32'(m_stk.size() == int'(SDEPTH)));
      check("stk_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
      check("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
      check("stk_udf", 32'(stk_udf), 32'(m_udf));
      if (lit_en) begin
        check({lit_nm, ".pc"}, 32'(instr_addr), 32'(lit_pc));
        check({lit_nm, ".depth"}, 32'(depth), 32'(lit_dep));
        check({lit_nm, ".ack"}, 32'(itr_ack), 32'(lit_ack));
        check({lit_nm, ".isr"}, 32'(in_isr), 32'(lit_isr));
        check({lit_nm, ".ovf"}, 32'(stk_ovf), 32'(lit_ovf));
        check({lit_nm, ".udf"}, 32'(stk_udf), 32'(lit_udf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic expect_lit(input string nm, input logic [MINSTW-1:0] pc, input int dep,
                            input logic [NITR-1:0] ack, input bit isr, input bit ovf, input bit udf);
    lit_nm = nm; lit_pc = pc; lit_dep = dep; lit_ack = ack;
    lit_isr = isr; lit_ovf = ovf; lit_udf = udf;
    lit_en = 1'b1;
  endtask

  task automatic idle();
    jmp = 1'b0; jz = 1'b0; acc_zero = 1'b0; call = 1'b0; ret = 1'b0; reti = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; itr = '0; itr_mask = '0; target = '0;
    idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    expect_lit("reset", 9'h000, 0, 4'b0000, 0, 0, 0);
    step();
    rst = 1'b1; en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(); expect_lit($sformatf("run%0d", i), MINSTW'(i), 0, 4'b0000, 0, 0, 0);
    end

    // call / ret round trip
    call = 1'b1; target = 9'h040;
    step(); expect_lit("call", 9'h040, 1, 4'b0000, 0, 0, 0);
    idle();
    step(); expect_lit("in_sub", 9'h041, 1, 4'b0000, 0, 0, 0);
    ret = 1'b1;
    step(); expect_lit("ret", 9'h004, 0, 4'b0000, 0, 0, 0);
    idle();

    // overflow on the ninth nested call, then underflow
    for (int i = 0; i < 9; i++) begin
      call = 1'b1; target = MINSTW'(9'h010 + i);
      step(); expect_lit($sformatf("ncall%0d", i), MINSTW'(9'h010 + i),
                         (i < 8) ? i + 1 : 8, 4'b0000, 0, (i == 8), 0);
    end
    idle();
    for (int j = 0; j < 8; j++) begin
      ret = 1'b1;
      step(); expect_lit($sformatf("nret%0d", j), (j < 7) ? MINSTW'(9'h017 - j) : 9'h005,
                         7 - j, 4'b0000, 0, 1, 0);
    end
    step(); expect_lit("udf_ret", 9'h006, 0, 4'b0000, 0, 1, 1);
    idle();

    // asynchronous reset mid-run, observed before any clock edge
    rst = 1'b0;
    expect_lit("async_rst", 9'h000, 0, 4'b0000, 0, 0, 0);
    step();
    rst = 1'b1;

    // conditional jump and address wrap
    jz = 1'b1; acc_zero = 1'b0; target = 9'h1FF;
    step(); expect_lit("jz_nt", 9'h001, 0, 4'b0000, 0, 0, 0);
    acc_zero = 1'b1;
    step(); expect_lit("jz_t", 9'h1FF, 0, 4'b0000, 0, 0, 0);
    idle();
    step(); expect_lit("wrap", 9'h000, 0, 4'b0000, 0, 0, 0);

    // simultaneous edges on lines 1 and 3
    itr = 4'b1010;
    step(); expect_lit("itr_lat", 9'h001, 0, 4'b0000, 0, 0, 0);
    step(); expect_lit("itr1", 9'h003, 1, 4'b0010, 1, 0, 0);
    itr = 4'b0000;
    step(); expect_lit("isr1_run", 9'h004, 1, 4'b0000, 1, 0, 0);
    reti = 1'b1;
    step(); expect_lit("reti1", 9'h002, 0, 4'b0000, 0, 0, 0);
    idle();
    step(); expect_lit("itr3", 9'h007, 1, 4'b1000, 1, 0, 0);
    reti = 1'b1;
    step(); expect_lit("reti3", 9'h003, 0, 4'b0000, 0, 0, 0);
    idle();

    // jump coinciding with an accepted interrupt
    itr = 4'b0001;
    step(); expect_lit("itr0_lat", 9'h004, 0, 4'b0000, 0, 0, 0);
    jmp = 1'b1; target = 9'h020;
    step(); expect_lit("jmp_itr0", 9'h001, 1, 4'b0001, 1, 0, 0);
    idle(); itr = 4'b0000; reti = 1'b1;
    step(); expect_lit("reti_jmp", 9'h020, 0, 4'b0000, 0, 0, 0);
    idle();

    // stall with an edge on line 2
    en = 1'b0; itr = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(); expect_lit($sformatf("stall%0d", i), 9'h020, 0, 4'b0000, 0, 0, 0);
    end
    en = 1'b1;
    step(); expect_lit("itr2", 9'h005, 1, 4'b0100, 1, 0, 0);
    itr = 4'b0101;
    step(); expect_lit("itr0_in2", 9'h006, 1, 4'b0000, 1, 0, 0);
`ifdef ITR_NEST_EN
    step(); expect_lit("nest0", 9'h001, 2, 4'b0001, 1, 0, 0);
    itr = 4'b0000; reti = 1'b1;
    step(); expect_lit("unwind0", 9'h007, 1, 4'b0000, 1, 0, 0);
    step(); expect_lit("unwind2", 9'h021, 0, 4'b0000, 0, 0, 0);
    idle();
`else
    step(); expect_lit("blocked0", 9'h007, 1, 4'b0000, 1, 0, 0);
    itr = 4'b0000; reti = 1'b1;
    step(); expect_lit("reti2", 9'h021, 0, 4'b0000, 0, 0, 0);
    idle();
    step(); expect_lit("late0", 9'h001, 1, 4'b0001, 1, 0, 0);
    reti = 1'b1;
    step(); expect_lit("reti0", 9'h022, 0, 4'b0000, 0, 0, 0);
    idle();
`endif

    // randomized strobes, stalls, edges and masks
    for (int c = 0; c < 4000; c++) begin
      int r;
      idle();
      en = ($urandom_range(0, 9) != 0);
      r = int'($urandom_range(0, 19));
      call = (r < 2); ret = (r == 2 || r == 3); reti = (r == 4 || r == 5);
      jmp = (r == 6); jz = (r == 7 || r == 8);
      if ($urandom_range(0, 15) == 0) begin
        call = ($urandom_range(0, 1) == 1); ret = ($urandom_range(0, 1) == 1);
        reti = ($urandom_range(0, 1) == 1); jmp = ($urandom_range(0, 1) == 1);
        jz = ($urandom_range(0, 1) == 1);
      end
      acc_zero = ($urandom_range(0, 1) == 1);
      target = ($urandom_range(0, 7) == 0) ? 9'h1FE : MINSTW'($urandom);
      if ($urandom_range(0, 3) == 0)  itr = NITR'($urandom);
      if ($urandom_range(0, 15) == 0) itr_mask = NITR'($urandom);
      step();
    end
    idle();
    step();
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
